// File: rtl/ballot_controller.sv
// Per-voter ballot sequencer: arms one ballot, accepts a single unambiguous press,
// pulses a one-hot counter increment, enforces a lockout, and owns poll closure.
module ballot_controller #(
    parameter int NUM_CAND       = 4,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int LOCKOUT_CYCLES = 100000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                arm,
    input  logic                close_poll,
    input  logic [NUM_CAND-1:0] cand_vote_valid,
    output logic [NUM_CAND-1:0] vote_inc,
    output logic                ballot_armed,
    output logic                busy,
    output logic                timeout_pulse,
    output logic                multi_press_pulse,
    output logic [15:0]         ballots_cast,
    output logic                result_mode
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_COMMIT  = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
    localparam logic [2:0] S_CLOSED  = 3'd4;

    // Timer counts cycles already spent in the state, so expiry is judged one short.
    localparam logic [30:0] TIMEOUT_LAST = 31'(TIMEOUT_CYCLES - 1);
    localparam logic [30:0] LOCKOUT_LAST = 31'(LOCKOUT_CYCLES - 1);
    localparam logic [NUM_CAND-1:0] CAND_ONE = {{(NUM_CAND-1){1'b0}}, 1'b1};

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [30:0]         timer;
    logic [30:0]         timer_nxt;
    logic [NUM_CAND-1:0] inc_nxt;
    logic                timeout_nxt;
    logic                multi_nxt;
    logic                any_press;
    logic                single_press;
    logic                multi_press;

    assign any_press    = |cand_vote_valid;
    assign single_press = any_press && ~|(cand_vote_valid & (cand_vote_valid - CAND_ONE));
    assign multi_press  = any_press && !single_press;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 31'd1;
        inc_nxt     = '0;
        timeout_nxt = 1'b0;
        multi_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (close_poll) begin
                    state_nxt = S_CLOSED;
                end else if (arm) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (single_press) begin
                    state_nxt = S_COMMIT;
                    inc_nxt   = cand_vote_valid;
                end else if (multi_press) begin
                    multi_nxt = 1'b1;
                end else if (timer >= TIMEOUT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_nxt = S_LOCKOUT;
                timer_nxt = '0;
            end
            S_LOCKOUT: begin
                if (timer >= LOCKOUT_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CLOSED: begin
                timer_nxt = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            timer             <= '0;
            vote_inc          <= '0;
            ballot_armed      <= 1'b0;
            busy              <= 1'b0;
            timeout_pulse     <= 1'b0;
            multi_press_pulse <= 1'b0;
            ballots_cast      <= '0;
            result_mode       <= 1'b0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            vote_inc          <= inc_nxt;
            ballot_armed      <= (state_nxt == S_ARMED);
            busy              <= (state_nxt == S_ARMED) || (state_nxt == S_COMMIT) ||
                                 (state_nxt == S_LOCKOUT);
            timeout_pulse     <= timeout_nxt;
            multi_press_pulse <= multi_nxt;
            result_mode       <= (state_nxt == S_CLOSED);
            if (state == S_COMMIT && ballots_cast != 16'hFFFF) begin
                ballots_cast <= ballots_cast + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: a voter-level model predicts every output each cycle.
module tb_ballot_controller;

    localparam int NC = 4;
    localparam int TO = 10;
    localparam int LO = 4;

    localparam int P_IDLE   = 0;
    localparam int P_ARMED  = 1;
    localparam int P_COMMIT = 2;
    localparam int P_LOCK   = 3;
    localparam int P_CLOSED = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic          close_poll;
    logic [NC-1:0] cand_vote_valid;
    logic [NC-1:0] vote_inc;
    logic          ballot_armed;
    logic          busy;
    logic          timeout_pulse;
    logic          multi_press_pulse;
    logic [15:0]   ballots_cast;
    logic          result_mode;

    ballot_controller #(
        .NUM_CAND      (NC),
        .TIMEOUT_CYCLES(TO),
        .LOCKOUT_CYCLES(LO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .arm              (arm),
        .close_poll       (close_poll),
        .cand_vote_valid  (cand_vote_valid),
        .vote_inc         (vote_inc),
        .ballot_armed     (ballot_armed),
        .busy             (busy),
        .timeout_pulse    (timeout_pulse),
        .multi_press_pulse(multi_press_pulse),
        .ballots_cast     (ballots_cast),
        .result_mode      (result_mode)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NC-1:0] inc;
        logic          armed;
        logic          busy;
        logic          to;
        logic          mp;
        logic          res;
        logic [15:0]   cast;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   done   = 1'b0;

    // Voter-level model: which phase the ballot is in, how long it has waited, votes counted.
    int m_phase  = P_IDLE;
    int m_waited = 0;
    int m_lock   = 0;
    int m_cast   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic cyc(input logic a, input logic c, input logic [NC-1:0] v, input logic r);
        exp_t e;
        arm             = a;
        close_poll      = c;
        cand_vote_valid = v;
        reset           = r;
        e = '0;
        if (r) begin
            m_phase = P_IDLE;
            m_cast  = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (c) m_phase = P_CLOSED;
                    else if (a) begin
                        m_phase  = P_ARMED;
                        m_waited = 0;
                    end
                end
                P_ARMED: begin
                    m_waited++;
                    if ($countones(v) == 1) begin
                        e.inc   = v;
                        m_phase = P_COMMIT;
                    end else if ($countones(v) > 1) begin
                        e.mp = 1'b1;
                    end else if (m_waited >= TO) begin
                        e.to    = 1'b1;
                        m_phase = P_IDLE;
                    end
                end
                P_COMMIT: begin
                    if (m_cast < 65535) m_cast++;
                    m_lock  = LO;
                    m_phase = P_LOCK;
                end
                P_LOCK: begin
                    m_lock--;
                    if (m_lock == 0) m_phase = P_IDLE;
                end
                default: ;
            endcase
        end
        e.armed = (m_phase == P_ARMED);
        e.busy  = (m_phase == P_ARMED) || (m_phase == P_COMMIT) || (m_phase == P_LOCK);
        e.res   = (m_phase == P_CLOSED);
        e.cast  = 16'(m_cast);
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic c);
        for (int i = 0; i < n; i++) cyc(1'b0, c, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                if (!done) begin
                    checks++;
                    $display("FAIL underflow: no expectation queued at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("vote_inc", 32'(vote_inc), 32'(e.inc));
                chk("ballot_armed", 32'(ballot_armed), 32'(e.armed));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("timeout_pulse", 32'(timeout_pulse), 32'(e.to));
                chk("multi_press_pulse", 32'(multi_press_pulse), 32'(e.mp));
                chk("result_mode", 32'(result_mode), 32'(e.res));
                chk("ballots_cast", 32'(ballots_cast), 32'(e.cast));
            end
        end
    end

    initial begin : stimulus
        logic [NC-1:0] v;
        logic          a;
        logic          c;
        logic          r;
        int            k;

        // Basic vote: arm at cycle 2, vote 0100 at cycle 5.
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(1, 0, '0, 0);
        idle(2, 0);
        cyc(0, 0, 4'b0100, 0);
        idle(8, 0);

        // Vote while idle, then arm and votes during commit/lockout.
        cyc(0, 0, 4'b0010, 0);
        cyc(1, 0, '0, 0);
        cyc(0, 0, 4'b1000, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'b0001, 0);
        idle(3, 0);

        // Multi-press then retry.
        cyc(1, 0, '0, 0);
        idle(2, 0);
        cyc(0, 0, 4'b0011, 0);
        idle(2, 0);
        cyc(0, 0, 4'b0001, 0);
        idle(7, 0);

        // Timeout with no vote, then a vote on the expiry cycle.
        cyc(1, 0, '0, 0);
        idle(12, 0);
        cyc(1, 0, '0, 0);
        idle(9, 0);
        cyc(0, 0, 4'b1000, 0);
        idle(7, 0);

        // Close requested while armed; honoured only after lockout.
        cyc(1, 0, '0, 0);
        cyc(0, 1, '0, 0);
        cyc(0, 1, 4'b0100, 0);
        idle(7, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'b0010, 0);
        cyc(0, 0, '0, 1);
        idle(2, 0);

        // Saturation of the ballot count.
        force dut.ballots_cast = 16'hFFFF;
        m_cast = 65535;
        idle(1, 0);
        release dut.ballots_cast;
        cyc(1, 0, '0, 0);
        cyc(0, 0, 4'b0001, 0);
        idle(7, 0);

        // Reset while in COMMIT.
        cyc(1, 0, '0, 0);
        cyc(0, 0, 4'b0100, 0);
        cyc(0, 0, '0, 1);
        idle(3, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6) v = '0;
            else if (k < 8) v = NC'(1 << $urandom_range(0, NC - 1));
            else v = NC'($urandom_range(0, (1 << NC) - 1));
            a = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 399) == 0);
            r = ($urandom_range(0, 149) == 0);
            cyc(a, c, v, r);
        end

        done = 1'b1;
        @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
